// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, step encoding and
// control-word bit positions. Optional feature macro: COND_JUMP_EN.
package ctrl_pkg;

    localparam int OPCODE_W  = 4;
    localparam int NUM_STEPS = 5;
    localparam int CW_W      = 17;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    // Bit 16 is internal only: it asks the step counter to enter HALT.
    localparam int CW_HLT      = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_PC_EN    = 2;
    localparam int CW_JMP      = 3;
    localparam int CW_MAR_IN   = 4;
    localparam int CW_RAM_IN   = 5;
    localparam int CW_RAM_OUT  = 6;
    localparam int CW_IR_IN    = 7;
    localparam int CW_IR_OUT   = 8;
    localparam int CW_A_IN     = 9;
    localparam int CW_A_OUT    = 10;
    localparam int CW_B_IN     = 11;
    localparam int CW_ALU_OUT  = 12;
    localparam int CW_ALU_SUB  = 13;
    localparam int CW_FLAGS_IN = 14;
    localparam int CW_OUT_IN   = 15;
    localparam int CW_HALT_REQ = 16;

    function automatic state_e step_next(input state_e cur);
        state_e nxt;
        case (cur)
            ST_T0:   nxt = ST_T1;
            ST_T1:   nxt = ST_T2;
            ST_T2:   nxt = ST_T3;
            ST_T3:   nxt = ST_T4;
            ST_T4:   nxt = ST_T0;
            default: nxt = ST_T0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/control_sequencer_tstate_counter.sv
// Five-step T-state counter with a sticky HALT state left only by reset.
module tstate_counter
    import ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   halt_req_i,
    output state_e state_o
);

    state_e state_q;
    state_e state_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance, wrap 4->0, or latch into HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: state_d = ST_HALT;
            ST_T0, ST_T1, ST_T2, ST_T3, ST_T4: begin
                if (halt_req_i) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = step_next(state_q);
                end
            end
            default: state_d = ST_T0;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: steps T0..T4 and decodes the control word.
// Optional feature macro: COND_JUMP_EN (enables JC/JZ; otherwise they are NOPs).
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic [2:0]          tstate,
    output logic                hlt,
    output logic                pc_out,
    output logic                pc_en,
    output logic                jmp,
    output logic                mar_in,
    output logic                ram_in,
    output logic                ram_out,
    output logic                ir_in,
    output logic                ir_out,
    output logic                a_in,
    output logic                a_out,
    output logic                b_in,
    output logic                alu_out,
    output logic                alu_sub,
    output logic                flags_in,
    output logic                out_in
);

    state_e          state_s;
    logic [CW_W-1:0] cw_s;

`ifndef COND_JUMP_EN
    logic unused_flags_s;
    assign unused_flags_s = carry_flag ^ zero_flag;
`endif

    tstate_counter u_tstate_counter (
        .clk        (clk),
        .reset      (reset),
        .halt_req_i (cw_s[CW_HALT_REQ]),
        .state_o    (state_s)
    );

    // Output decode: control word from step, opcode and flags
    always_comb begin
        cw_s = {CW_W{1'b0}};
        case (state_s)
            ST_T0: begin
                cw_s[CW_PC_OUT] = 1'b1;
                cw_s[CW_MAR_IN] = 1'b1;
            end
            ST_T1: begin
                cw_s[CW_RAM_OUT] = 1'b1;
                cw_s[CW_IR_IN]   = 1'b1;
                cw_s[CW_PC_EN]   = 1'b1;
            end
            ST_T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw_s[CW_IR_OUT] = 1'b1;
                        cw_s[CW_MAR_IN] = 1'b1;
                    end
                    OP_LDI: begin
                        cw_s[CW_IR_OUT] = 1'b1;
                        cw_s[CW_A_IN]   = 1'b1;
                    end
                    OP_JMP: begin
                        cw_s[CW_IR_OUT] = 1'b1;
                        cw_s[CW_JMP]    = 1'b1;
                    end
`ifdef COND_JUMP_EN
                    OP_JC: begin
                        if (carry_flag) begin
                            cw_s[CW_IR_OUT] = 1'b1;
                            cw_s[CW_JMP]    = 1'b1;
                        end else begin
                            cw_s = {CW_W{1'b0}};
                        end
                    end
                    OP_JZ: begin
                        if (zero_flag) begin
                            cw_s[CW_IR_OUT] = 1'b1;
                            cw_s[CW_JMP]    = 1'b1;
                        end else begin
                            cw_s = {CW_W{1'b0}};
                        end
                    end
`endif
                    OP_OUT: begin
                        cw_s[CW_A_OUT]  = 1'b1;
                        cw_s[CW_OUT_IN] = 1'b1;
                    end
                    // The visible word stays zero; only the counter sees the request.
                    OP_HLT:  cw_s[CW_HALT_REQ] = 1'b1;
                    default: cw_s = {CW_W{1'b0}};
                endcase
            end
            ST_T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw_s[CW_RAM_OUT] = 1'b1;
                        cw_s[CW_A_IN]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw_s[CW_RAM_OUT] = 1'b1;
                        cw_s[CW_B_IN]    = 1'b1;
                    end
                    OP_STA: begin
                        cw_s[CW_A_OUT]  = 1'b1;
                        cw_s[CW_RAM_IN] = 1'b1;
                    end
                    default: cw_s = {CW_W{1'b0}};
                endcase
            end
            ST_T4: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        cw_s[CW_ALU_OUT]  = 1'b1;
                        cw_s[CW_A_IN]     = 1'b1;
                        cw_s[CW_FLAGS_IN] = 1'b1;
                        cw_s[CW_ALU_SUB]  = (opcode == OP_SUB);
                    end
                    default: cw_s = {CW_W{1'b0}};
                endcase
            end
            ST_HALT: cw_s[CW_HLT] = 1'b1;
            default: cw_s = {CW_W{1'b0}};
        endcase
    end

    assign tstate   = state_s;
    assign hlt      = cw_s[CW_HLT];
    assign pc_out   = cw_s[CW_PC_OUT];
    assign pc_en    = cw_s[CW_PC_EN];
    assign jmp      = cw_s[CW_JMP];
    assign mar_in   = cw_s[CW_MAR_IN];
    assign ram_in   = cw_s[CW_RAM_IN];
    assign ram_out  = cw_s[CW_RAM_OUT];
    assign ir_in    = cw_s[CW_IR_IN];
    assign ir_out   = cw_s[CW_IR_OUT];
    assign a_in     = cw_s[CW_A_IN];
    assign a_out    = cw_s[CW_A_OUT];
    assign b_in     = cw_s[CW_B_IN];
    assign alu_out  = cw_s[CW_ALU_OUT];
    assign alu_sub  = cw_s[CW_ALU_SUB];
    assign flags_in = cw_s[CW_FLAGS_IN];
    assign out_in   = cw_s[CW_OUT_IN];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer; expectations written by hand.
module tb_control_sequencer;

    localparam logic [15:0] B_HLT      = 16'h8000;
    localparam logic [15:0] B_PC_OUT   = 16'h4000;
    localparam logic [15:0] B_PC_EN    = 16'h2000;
    localparam logic [15:0] B_JMP      = 16'h1000;
    localparam logic [15:0] B_MAR_IN   = 16'h0800;
    localparam logic [15:0] B_RAM_IN   = 16'h0400;
    localparam logic [15:0] B_RAM_OUT  = 16'h0200;
    localparam logic [15:0] B_IR_IN    = 16'h0100;
    localparam logic [15:0] B_IR_OUT   = 16'h0080;
    localparam logic [15:0] B_A_IN     = 16'h0040;
    localparam logic [15:0] B_A_OUT    = 16'h0020;
    localparam logic [15:0] B_B_IN     = 16'h0010;
    localparam logic [15:0] B_ALU_OUT  = 16'h0008;
    localparam logic [15:0] B_ALU_SUB  = 16'h0004;
    localparam logic [15:0] B_FLAGS_IN = 16'h0002;
    localparam logic [15:0] B_OUT_IN   = 16'h0001;
    localparam logic [15:0] W_ZERO     = 16'h0000;

    localparam logic [15:0] W_F0 = B_PC_OUT | B_MAR_IN;
    localparam logic [15:0] W_F1 = B_RAM_OUT | B_IR_IN | B_PC_EN;
    localparam logic [15:0] W_JUMP = B_IR_OUT | B_JMP;
`ifdef COND_JUMP_EN
    localparam logic [15:0] W_CJ_TAKEN = W_JUMP;
`else
    localparam logic [15:0] W_CJ_TAKEN = W_ZERO;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       carry_flag, zero_flag;
    logic [2:0] tstate;
    logic hlt, pc_out, pc_en, jmp, mar_in, ram_in, ram_out, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in;
    logic [15:0] obs;
    int tests;
    int fails;

    control_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .tstate(tstate), .hlt(hlt), .pc_out(pc_out), .pc_en(pc_en), .jmp(jmp),
        .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in),
        .ir_out(ir_out), .a_in(a_in), .a_out(a_out), .b_in(b_in),
        .alu_out(alu_out), .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in)
    );

    assign obs = {hlt, pc_out, pc_en, jmp, mar_in, ram_in, ram_out, ir_in, ir_out,
                  a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] exp_t, input logic [15:0] exp_w);
        tests++;
        assert (tstate === exp_t && obs === exp_w)
        else begin
            fails++;
            $error("FAIL %s: observed tstate=%0d word=%h, expected tstate=%0d word=%h",
                   tag, tstate, obs, exp_t, exp_w);
        end
    endtask

    // Starts at a negedge in T0; ends at the negedge of the following T0.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic c,
                             input logic z, input logic [15:0] w2,
                             input logic [15:0] w3, input logic [15:0] w4);
        opcode = op; carry_flag = c; zero_flag = z;
        check({tag, "_T0"}, 3'd0, W_F0);
        @(negedge clk); check({tag, "_T1"}, 3'd1, W_F1);
        @(negedge clk); check({tag, "_T2"}, 3'd2, w2);
        @(negedge clk); check({tag, "_T3"}, 3'd3, w3);
        @(negedge clk); check({tag, "_T4"}, 3'd4, w4);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rop;
        tests = 0; fails = 0;
        reset = 1'b1; opcode = 4'h1; carry_flag = 1'b0; zero_flag = 1'b0;
        #2 check("reset", 3'd0, W_F0);
        @(negedge clk); reset = 1'b0;

        run_instr("add", 4'h1, 1'b0, 1'b0, B_IR_OUT | B_MAR_IN, B_RAM_OUT | B_B_IN,
                  B_ALU_OUT | B_A_IN | B_FLAGS_IN);
        check("add_wrap", 3'd0, W_F0);
        run_instr("sub", 4'h2, 1'b0, 1'b0, B_IR_OUT | B_MAR_IN, B_RAM_OUT | B_B_IN,
                  B_ALU_OUT | B_A_IN | B_FLAGS_IN | B_ALU_SUB);
        run_instr("lda", 4'h0, 1'b0, 1'b0, B_IR_OUT | B_MAR_IN, B_RAM_OUT | B_A_IN, W_ZERO);
        run_instr("sta", 4'h4, 1'b0, 1'b0, B_IR_OUT | B_MAR_IN, B_A_OUT | B_RAM_IN, W_ZERO);
        run_instr("ldi", 4'h5, 1'b0, 1'b0, B_IR_OUT | B_A_IN, W_ZERO, W_ZERO);
        run_instr("jmp", 4'h6, 1'b0, 1'b0, W_JUMP, W_ZERO, W_ZERO);
        run_instr("jc_c0", 4'h7, 1'b0, 1'b1, W_ZERO, W_ZERO, W_ZERO);
        run_instr("jc_c1", 4'h7, 1'b1, 1'b0, W_CJ_TAKEN, W_ZERO, W_ZERO);
        run_instr("jz_z0", 4'h8, 1'b1, 1'b0, W_ZERO, W_ZERO, W_ZERO);
        run_instr("jz_z1", 4'h8, 1'b0, 1'b1, W_CJ_TAKEN, W_ZERO, W_ZERO);
        run_instr("out", 4'hE, 1'b0, 1'b0, B_A_OUT | B_OUT_IN, W_ZERO, W_ZERO);
        run_instr("nop3", 4'h3, 1'b1, 1'b1, W_ZERO, W_ZERO, W_ZERO);
        check("nop3_nohalt", 3'd0, W_F0);

        // Reset pulse in the middle of T3 of an ADD
        opcode = 4'h1; carry_flag = 1'b0; zero_flag = 1'b0;
        check("mid_T0", 3'd0, W_F0);
        @(negedge clk); check("mid_T1", 3'd1, W_F1);
        @(negedge clk); check("mid_T2", 3'd2, B_IR_OUT | B_MAR_IN);
        @(negedge clk); check("mid_T3", 3'd3, B_RAM_OUT | B_B_IN);
        #2 reset = 1'b1;
        #1 check("mid_reset", 3'd0, W_F0);
        #1 reset = 1'b0;
        @(negedge clk); check("mid_after", 3'd1, W_F1);
        repeat (4) @(negedge clk);
        check("mid_resume", 3'd0, W_F0);

        // Halt: T2 word zero, then HALT is sticky until reset
        opcode = 4'hF;
        check("hlt_T0", 3'd0, W_F0);
        @(negedge clk); check("hlt_T1", 3'd1, W_F1);
        @(negedge clk); check("hlt_T2", 3'd2, W_ZERO);
        @(negedge clk); check("hlt_enter", 3'd5, B_HLT);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); check("hlt_stay", 3'd5, B_HLT);
        end
        #1 reset = 1'b1;
        #1 check("hlt_reset", 3'd0, W_F0);
        @(negedge clk); reset = 1'b0;
        check("hlt_released", 3'd0, W_F0);
        @(negedge clk); check("hlt_restart", 3'd1, W_F1);

        // Random opcodes/flags: invariants every cycle (HLT excluded)
        for (int i = 0; i < 1000; i++) begin
            rop = 4'($urandom_range(0, 14));
            opcode = rop;
            carry_flag = 1'($urandom_range(0, 1));
            zero_flag = 1'($urandom_range(0, 1));
            #1;
            tests++;
            assert (!(pc_en && jmp))
            else begin
                fails++;
                $error("FAIL rand_pc_jmp: observed pc_en=%b jmp=%b, expected not both 1", pc_en, jmp);
            end
            tests++;
            assert ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1)
            else begin
                fails++;
                $error("FAIL rand_bus: observed drivers=%b, expected at most one set",
                       {pc_out, ram_out, ir_out, a_out, alu_out});
            end
            tests++;
            assert (tstate <= 3'd4 && hlt === 1'b0)
            else begin
                fails++;
                $error("FAIL rand_state: observed tstate=%0d hlt=%b, expected tstate<=4 hlt=0",
                       tstate, hlt);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
